// File: rtl/queue_monitor.sv
// Door-sensor queue monitor: debounced entry/exit events, saturating occupancy
// count with sticky errors, and a sequentially divided wait-time estimate.

module queue_monitor_sensor #(
    parameter int DEB = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic evt
);
    localparam int DCW = (DEB < 2) ? 1 : $clog2(DEB + 1);

    logic           s1, s2, d;
    logic [DCW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1  <= 1'b1;
            s2  <= 1'b1;
            d   <= 1'b1;
            cnt <= '0;
            evt <= 1'b0;
        end else begin
            s1  <= raw;
            s2  <= s1;
            evt <= 1'b0;
            if (s2 != d) begin
                if (cnt == DCW'(DEB - 1)) begin
                    d   <= s2;
                    cnt <= '0;
                    // only the falling (person arrives) edge is an event
                    evt <= d & ~s2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

module queue_monitor #(
    parameter int CW  = 3,
    parameter int TW  = 2,
    parameter int ST  = 3,
    parameter int DEB = 2,
    parameter int WW  = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          x_in,
    input  logic          x_out,
    input  logic [TW-1:0] tcount,
    input  logic          clr_err,
    output logic          in_evt,
    output logic          out_evt,
    output logic [CW-1:0] pcount,
    output logic          full,
    output logic          empty,
    output logic          ovf,
    output logic          udf,
    output logic [WW-1:0] wtime,
    output logic          wvalid
);
    localparam int NW = CW + 1;
    localparam int IW = $clog2(NW + 1);
    localparam logic [CW-1:0] MAXP = '1;
    localparam logic [31:0]   WMAX = (32'd1 << WW) - 32'd1;

    typedef enum logic [1:0] {IDLE, DIV, DONE} dstate_t;

    queue_monitor_sensor #(.DEB(DEB)) u_in  (.clk(clk), .reset(reset), .raw(x_in),  .evt(in_evt));
    queue_monitor_sensor #(.DEB(DEB)) u_out (.clk(clk), .reset(reset), .raw(x_out), .evt(out_evt));

    // ---------------- occupancy ----------------
    logic          inc, dec, ovf_set, udf_set;
    logic [CW-1:0] pcount_nxt;

    assign inc = in_evt & ~out_evt;
    assign dec = out_evt & ~in_evt;

    always_comb begin
        pcount_nxt = pcount;
        ovf_set    = 1'b0;
        udf_set    = 1'b0;
        if (inc) begin
            if (full) ovf_set    = 1'b1;
            else      pcount_nxt = pcount + 1'b1;
        end
        if (dec) begin
            if (empty) udf_set    = 1'b1;
            else       pcount_nxt = pcount - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pcount <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            pcount <= pcount_nxt;
            full   <= (pcount_nxt == MAXP);
            empty  <= (pcount_nxt == '0);
            // a fresh error outranks a simultaneous clear
            ovf    <= ovf_set | (ovf & ~clr_err);
            udf    <= udf_set | (udf & ~clr_err);
        end
    end

    // ---------------- wait-time divider ----------------
    dstate_t       state;
    logic [CW-1:0] p_l;
    logic [TW-1:0] t_l, teff, rem, rem_nxt;
    logic [NW-1:0] num, quo;
    logic [IW-1:0] iter;
    logic [TW:0]   rem_sh;
    logic          ge, changed;
    logic [31:0]   prod;
    logic [WW-1:0] wsat;

    assign teff    = (tcount == '0) ? TW'(1) : tcount;
    assign changed = (pcount != p_l) || (teff != t_l);

    always_comb begin
        rem_sh  = {rem, num[NW-1]};
        ge      = (rem_sh >= {1'b0, t_l});
        rem_nxt = ge ? TW'(rem_sh - {1'b0, t_l}) : TW'(rem_sh);
        prod    = 32'(ST) * 32'(quo);
        wsat    = (prod > WMAX) ? WMAX[WW-1:0] : prod[WW-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            p_l    <= '0;
            t_l    <= TW'(1);
            num    <= '0;
            rem    <= '0;
            quo    <= '0;
            iter   <= '0;
            wtime  <= '0;
            wvalid <= 1'b1;
        end else if (changed) begin
            // operands moved: (re)start from scratch, stale result never lands
            p_l    <= pcount;
            t_l    <= teff;
            num    <= {1'b0, pcount} + NW'(teff) - NW'(1);
            rem    <= '0;
            quo    <= '0;
            iter   <= '0;
            wvalid <= 1'b0;
            state  <= DIV;
        end else begin
            case (state)
                DIV: begin
                    num  <= num << 1;
                    rem  <= rem_nxt;
                    quo  <= {quo[NW-2:0], ge};
                    iter <= iter + 1'b1;
                    if (iter == IW'(CW)) state <= DONE;
                end
                DONE: begin
                    wtime  <= wsat;
                    wvalid <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_queue_monitor.sv
// Directed bench for queue_monitor: vector table of door operations plus
// hand sequences for latency, reset abort, error precedence and divider restart.

module tb_queue_monitor;
    localparam int CW = 3, TW = 2, ST = 3, DEB = 2, WW = 8;
    localparam int OP_NONE = 0, OP_ENT = 1, OP_EXT = 2, OP_BOTH = 3;

    logic          clk = 1'b0;
    logic          reset, x_in, x_out, clr_err;
    logic [TW-1:0] tcount;
    logic          in_evt, out_evt, full, empty, ovf, udf, wvalid;
    logic [CW-1:0] pcount;
    logic [WW-1:0] wtime;
    logic          in_evt_b, out_evt_b, full_b, empty_b, ovf_b, udf_b, wvalid_b;
    logic [CW-1:0] pcount_b;
    logic [3:0]    wtime_b;

    int nerr = 0;
    int nchk = 0;

    always #5 clk = ~clk;

    queue_monitor #(.CW(CW), .TW(TW), .ST(ST), .DEB(DEB), .WW(WW)) dut (
        .clk(clk), .reset(reset), .x_in(x_in), .x_out(x_out), .tcount(tcount),
        .clr_err(clr_err), .in_evt(in_evt), .out_evt(out_evt), .pcount(pcount),
        .full(full), .empty(empty), .ovf(ovf), .udf(udf), .wtime(wtime), .wvalid(wvalid));

    queue_monitor #(.CW(CW), .TW(TW), .ST(ST), .DEB(DEB), .WW(4)) dut_b (
        .clk(clk), .reset(reset), .x_in(x_in), .x_out(x_out), .tcount(tcount),
        .clr_err(clr_err), .in_evt(in_evt_b), .out_evt(out_evt_b), .pcount(pcount_b),
        .full(full_b), .empty(empty_b), .ovf(ovf_b), .udf(udf_b), .wtime(wtime_b), .wvalid(wvalid_b));

    typedef struct {
        int         op;
        logic [1:0] tc;
        int         p;
        int         w;
        bit         full;
        bit         empty;
        bit         ovf;
        bit         udf;
    } row_t;

    row_t rows[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 40 && !wvalid; i++) tick();
        check(name, wvalid, 1);
    endtask

    // sensor held low for DEB+3 samples, then released and allowed to settle
    task automatic do_op(input int op, output int nin, output int nout, output int nin_b, output int nout_b);
        nin = 0; nout = 0; nin_b = 0; nout_b = 0;
        if (op == OP_ENT || op == OP_BOTH) x_in  = 1'b0;
        if (op == OP_EXT || op == OP_BOTH) x_out = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (in_evt)    nin++;
            if (out_evt)   nout++;
            if (in_evt_b)  nin_b++;
            if (out_evt_b) nout_b++;
            if (c == 4) begin
                x_in  = 1'b1;
                x_out = 1'b1;
            end
        end
    endtask

    task automatic run_rows(input int lo, input int hi);
        int nin, nout, nin_b, nout_b, ew, ew4;
        for (int i = lo; i <= hi; i++) begin
            tcount = rows[i].tc;
            do_op(rows[i].op, nin, nout, nin_b, nout_b);
            wait_valid($sformatf("row%0d_wvalid", i));
            ew  = rows[i].w;
            ew4 = (ew > 15) ? 15 : ew;
            check($sformatf("row%0d_in_evt", i),  nin,  (rows[i].op == OP_ENT || rows[i].op == OP_BOTH) ? 1 : 0);
            check($sformatf("row%0d_out_evt", i), nout, (rows[i].op == OP_EXT || rows[i].op == OP_BOTH) ? 1 : 0);
            check($sformatf("row%0d_pcount", i), pcount, rows[i].p);
            check($sformatf("row%0d_wtime", i),  wtime,  ew);
            check($sformatf("row%0d_flags", i),  {full, empty, ovf, udf},
                  {rows[i].full, rows[i].empty, rows[i].ovf, rows[i].udf});
            check($sformatf("row%0d_b_evt", i),  {nin_b, nout_b}, {nin, nout});
            check($sformatf("row%0d_b_pcount", i), pcount_b, rows[i].p);
            check($sformatf("row%0d_b_flags", i), {full_b, empty_b, ovf_b, udf_b},
                  {rows[i].full, rows[i].empty, rows[i].ovf, rows[i].udf});
            check($sformatf("row%0d_b_wvalid", i), wvalid_b, 1);
            check($sformatf("row%0d_b_wtime", i),  wtime_b, ew4);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", nerr);
        $fatal(1);
    end

    initial begin
        int low;
        //              op       tc    p   w  full empty ovf udf
        rows[0]  = '{OP_ENT,  2'd1, 2,  6, 0, 0, 0, 0};
        rows[1]  = '{OP_ENT,  2'd1, 3,  9, 0, 0, 0, 0};
        rows[2]  = '{OP_ENT,  2'd1, 4, 12, 0, 0, 0, 0};
        rows[3]  = '{OP_ENT,  2'd1, 5, 15, 0, 0, 0, 0};
        rows[4]  = '{OP_NONE, 2'd2, 5,  9, 0, 0, 0, 0};
        rows[5]  = '{OP_NONE, 2'd3, 5,  6, 0, 0, 0, 0};
        rows[6]  = '{OP_NONE, 2'd0, 5, 15, 0, 0, 0, 0};
        rows[7]  = '{OP_ENT,  2'd1, 6, 18, 0, 0, 0, 0};
        rows[8]  = '{OP_ENT,  2'd1, 7, 21, 1, 0, 0, 0};
        rows[9]  = '{OP_ENT,  2'd1, 7, 21, 1, 0, 1, 0};
        rows[10] = '{OP_EXT,  2'd1, 6, 18, 0, 0, 0, 0};
        rows[11] = '{OP_EXT,  2'd1, 5, 15, 0, 0, 0, 0};
        rows[12] = '{OP_EXT,  2'd1, 4, 12, 0, 0, 0, 0};
        rows[13] = '{OP_EXT,  2'd1, 3,  9, 0, 0, 0, 0};
        rows[14] = '{OP_BOTH, 2'd1, 3,  9, 0, 0, 0, 0};
        rows[15] = '{OP_EXT,  2'd1, 2,  6, 0, 0, 0, 0};
        rows[16] = '{OP_EXT,  2'd1, 1,  3, 0, 0, 0, 0};
        rows[17] = '{OP_EXT,  2'd1, 0,  0, 0, 1, 0, 0};
        rows[18] = '{OP_EXT,  2'd1, 0,  0, 0, 1, 0, 1};

        // reset state, then reset aborting a division in flight
        reset = 1'b1; x_in = 1'b1; x_out = 1'b1; tcount = 2'd2; clr_err = 1'b0;
        tick(); tick();
        check("rst_pcount", pcount, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_wtime", wtime, 0);
        check("rst_wvalid", wvalid, 1);
        check("rst_errs", {ovf, udf}, 0);
        check("rst_evts", {in_evt, out_evt}, 0);
        reset = 1'b0;
        tick();
        check("rst_release_latch", wvalid, 0);
        tick(); tick();
        reset = 1'b1; tcount = 2'd1;
        tick();
        check("rst_mid_div_wvalid", wvalid, 1);
        check("rst_mid_div_wtime", wtime, 0);
        check("rst_mid_div_pcount", pcount, 0);
        reset = 1'b0;
        tick(); tick();
        check("idle_after_reset", wvalid, 1);

        // glitch shorter than the debounce window
        low = 0;
        x_in = 1'b0;
        tick();
        x_in = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (in_evt) low++;
        end
        check("glitch_no_evt", low, 0);
        check("glitch_pcount", pcount, 0);

        // entry latency and divider timing (first low sample at edge c=0)
        x_in = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (c == 4) x_in = 1'b1;
            check($sformatf("lat%0d_in_evt", c), in_evt, (c == 3) ? 1 : 0);
            check($sformatf("lat%0d_pcount", c), pcount, (c >= 4) ? 1 : 0);
            check($sformatf("lat%0d_wvalid", c), wvalid, (c >= 5 && c <= 9) ? 0 : 1);
            check($sformatf("lat%0d_wtime", c), wtime, (c >= 10) ? 3 : 0);
        end
        repeat (4) tick();

        run_rows(0, 9);

        // clear alone, then a new overflow coinciding with clear
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("clr_ovf", ovf, 0);
        x_in = 1'b0;
        repeat (4) tick();
        check("err_clr_evt", in_evt, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0; x_in = 1'b1;
        check("err_beats_clr", ovf, 1);
        check("err_beats_clr_pcount", pcount, 7);
        repeat (8) tick();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("clr_ovf2", {ovf, ovf_b}, 0);

        run_rows(10, 11);

        // teller count changes mid-division at pcount=5
        tcount = 2'd2;
        tick();
        check("restart_latch_wvalid", wvalid, 0);
        low = 1;
        tick();
        low++;
        tcount = 2'd3;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (wvalid) break;
            low++;
            check("restart_hold_wtime", wtime, 15);
        end
        check("restart_low_cycles", low, 7);
        check("restart_wtime", wtime, 6);

        run_rows(12, 18);

        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("clr_udf", udf, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/queue_monitor.md
Name: queue_monitor

Overview:
- Parametrised successor of the single-queue people counter.
- Conditions two active-low presence sensors (entry and exit) with synchronisers and debounce, and turns them into one-cycle events.
- Keeps a saturating occupancy count with full/empty flags and sticky overflow/underflow errors.
- Computes the estimated wait time ST*ceil(pcount/tellers) with a sequential divider that has a valid flag. Sits between the door sensors and the display/ROM stage.

Parameters:
CW, 3, occupancy counter width; MAXP = 2^CW-1
TW, 2, active-teller count width
ST, 3, service time units per queue slot
DEB, 2, consecutive stable samples for debounce (>=1)
WW, 8, wait-time output width

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
x_in  in  1  entry sensor raw, 0 = person present
x_out  in  1  exit sensor raw, 0 = person present
tcount  in  TW  number of active tellers, 0 treated as 1
clr_err  in  1  clears ovf/udf
in_evt  out  1  one-cycle pulse, entry accepted edge
out_evt  out  1  one-cycle pulse, exit edge
pcount  out  CW  current occupancy
full  out  1  pcount == MAXP
empty  out  1  pcount == 0
ovf  out  1  sticky: entry while full
udf  out  1  sticky: exit while empty
wtime  out  WW  estimated wait
wvalid  out  1  wtime consistent with current pcount/tcount

Behaviour:
- Reset (sync, active-high; clk/reset fixed): at the next edge pcount=0, empty=1, full=0, ovf=0, udf=0, in_evt=out_evt=0, wtime=0, wvalid=1.
  - Sync flops, debounced states: 1.
  - Debounce counters: 0; divider idle.
  - Latched operands: p=0, t=1.
  - Reset mid-debounce or mid-division aborts both, with no event and no wtime update.
- Per sensor conditioning:
  - 2-flop synchroniser (s1, s2).
  - Debounced state d changes only after s2 differs from d for DEB consecutive edges; any agreement restarts the count.
  - Event pulse when d goes 1->0. Release (0->1) produces no event.
  - Latency: raw low first sampled at edge k gives d=0 at edge k+1+DEB, evt high for the cycle after it, and pcount updated at edge k+2+DEB.
  - A low pulse shorter than DEB synchronised samples gives no event.
- Count update, per edge with ev_in/ev_out:
  - in only, not full: +1.
  - out only, not empty: -1.
  - Both: no change, no error.
  - in while full: hold, ovf<=1.
  - out while empty: hold, udf<=1.
  - in_evt/out_evt pulse whenever the debounced edge occurs, even when the count holds.
  - clr_err clears ovf/udf; a new error in the same cycle wins (flag stays 1).
- full/empty are registered with pcount (same edge).
- Wait time:
  - teff = (tcount==0) ? 1 : tcount.
  - q = floor((p + teff - 1)/teff), numerator CW+1 bits.
  - wtime = min(ST*q, 2^WW-1).
- Divider FSM:
  - IDLE: if (pcount, teff) != latched, latch them, wvalid<=0, go to DIV.
  - DIV: restoring division, one quotient bit per cycle, CW+1 iterations, then go to DONE.
  - DONE: wtime<=sat(ST*q), wvalid<=1, go to IDLE.
  - Total: wvalid low for CW+2 cycles from the latch edge.
  - If pcount/teff changes during DIV or DONE, do not write wtime; relatch and restart at the next edge; wvalid stays 0.
  - wtime holds its previous value while wvalid=0.
- No combinational path from inputs to outputs.

Test Plan:
1. Reset with x_in=x_out=1, tcount=2 -> pcount=0, empty=1, full=0, wtime=0, wvalid=1, ovf=udf=0. Re-assert reset mid-division -> same values next edge.
2. x_in low 1 cycle -> no in_evt, pcount 0. x_in low 5 cycles, tcount=1 -> in_evt one cycle, pcount=1 at edge k+4, wvalid=0 for 5 cycles, then wtime=3.
3. Eight debounced entries, tcount=1 -> pcount saturates at 7, full=1, wtime=21, ovf=1 after 8th. clr_err -> ovf=0. Error and clr_err in the same cycle -> ovf=1.
4. pcount=5: tcount=2 -> wtime=9; tcount=3 -> 6; tcount=0 -> 15. Change tcount 2->3 during DIV -> restart, no intermediate wtime, final 6.
5. pcount=3, entry and exit events on the same edge -> pcount stays 3, no flags. Exit at pcount=0 -> udf=1, empty=1, out_evt pulses.
6. WW=4, ST=3, CW=3, tcount=1, pcount=7 -> wtime=15 (saturated from 21).
